// File: rtl/oam_dma_ctrl.sv
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : OAM DMA sequencer: FF46 write copies DMA_LENGTH bytes from
//                {src,8'h00} into OAM. Optional macro DMA_CPU_STALL_EN drives
//                oCpuStall from oBusy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma_ctrl #(
    parameter int DMA_LENGTH  = 160,
    parameter int START_DELAY = 2
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iDmaWe,
    input  logic [7:0]  iDmaData,
    output logic [15:0] oMcuAddr,
    output logic        oMcuReadReq,
    input  logic        iMcuReadAck,
    input  logic [7:0]  iMcuReadData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData,
    output logic [7:0]  oDMA,
    output logic        oBusy,
    output logic        oDone,
    output logic        oCpuStall
);

    localparam int c_DLY_W = (START_DELAY < 2) ? 1 : $clog2(START_DELAY);
    localparam logic [c_DLY_W-1:0] c_DLY_LAST =
        c_DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [7:0] c_LAST_IDX = 8'(DMA_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam state_t c_START_STATE = (START_DELAY == 0) ? S_READ : S_DELAY;

    state_t              r_state_q, w_state_d;
    logic [7:0]          r_index_q, w_index_d;
    logic [c_DLY_W-1:0]  r_dly_q,   w_dly_d;
    logic [7:0]          r_src_q,   w_src_d;
    logic [7:0]          r_dma_q,   w_dma_d;
    logic [7:0]          r_data_q,  w_data_d;
    logic                r_done_q,  w_done_d;
    logic [7:0]          w_src_eff;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state_q <= S_IDLE;
            r_index_q <= 8'h00;
            r_dly_q   <= '0;
            r_src_q   <= 8'h00;
            r_dma_q   <= 8'h00;
            r_data_q  <= 8'h00;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_index_q <= w_index_d;
            r_dly_q   <= w_dly_d;
            r_src_q   <= w_src_d;
            r_dma_q   <= w_dma_d;
            r_data_q  <= w_data_d;
            r_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_index_d = r_index_q;
        w_dly_d   = r_dly_q;
        w_src_d   = r_src_q;
        w_dma_d   = r_dma_q;
        w_data_d  = r_data_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            S_DELAY: begin
                if (r_dly_q == c_DLY_LAST) begin
                    w_state_d = S_READ;
                end else begin
                    w_dly_d = r_dly_q + 1'b1;
                end
            end
            S_READ: begin
                if (iMcuReadAck) begin
                    w_data_d  = iMcuReadData;
                    w_state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_index_q == c_LAST_IDX) begin
                    w_state_d = S_IDLE;
                    w_done_d  = 1'b1;
                end else begin
                    w_index_d = r_index_q + 8'h01;
                    w_state_d = S_READ;
                end
            end
            default: begin
            end
        endcase

        // A new FF46 write overrides whatever the transfer was doing.
        if (iDmaWe) begin
            w_src_d   = iDmaData;
            w_dma_d   = iDmaData;
            w_index_d = 8'h00;
            w_dly_d   = '0;
            w_state_d = c_START_STATE;
            w_done_d  = 1'b0;
        end
    end

    // Echo RAM E000-FDFF mirrors C000-DDFF.
    assign w_src_eff   = (r_src_q >= 8'hE0) ? (r_src_q - 8'h20) : r_src_q;

    assign oMcuReadReq = (r_state_q == S_READ);
    assign oMcuAddr    = oMcuReadReq ? {w_src_eff, r_index_q} : 16'h0000;
    assign oOamWe      = (r_state_q == S_WRITE);
    assign oOamAddr    = oOamWe ? r_index_q : 8'h00;
    assign oOamData    = oOamWe ? r_data_q : 8'h00;
    assign oDMA        = r_dma_q;
    assign oBusy       = (r_state_q != S_IDLE);
    assign oDone       = r_done_q;

`ifdef DMA_CPU_STALL_EN
    assign oCpuStall   = oBusy;
`else
    assign oCpuStall   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
// ============================================================================
//  Module      : tb_oam_dma_ctrl
//  Description : Self-checking bench for oam_dma_ctrl (vector table plus
//                full-transfer sequences with a simple memory responder).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oam_dma_ctrl;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iDmaWe;
    logic [7:0]  iDmaData;
    logic [15:0] oMcuAddr;
    logic        oMcuReadReq;
    logic        iMcuReadAck;
    logic [7:0]  iMcuReadData;
    logic        oOamWe;
    logic [7:0]  oOamAddr;
    logic [7:0]  oOamData;
    logic [7:0]  oDMA;
    logic        oBusy;
    logic        oDone;
    logic        oCpuStall;

    int checks = 0;
    int errors = 0;

    always #5 iClock = ~iClock;

    oam_dma_ctrl #(
        .DMA_LENGTH  (160),
        .START_DELAY (2)
    ) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iDmaWe       (iDmaWe),
        .iDmaData     (iDmaData),
        .oMcuAddr     (oMcuAddr),
        .oMcuReadReq  (oMcuReadReq),
        .iMcuReadAck  (iMcuReadAck),
        .iMcuReadData (iMcuReadData),
        .oOamWe       (oOamWe),
        .oOamAddr     (oOamAddr),
        .oOamData     (oOamData),
        .oDMA         (oDMA),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oCpuStall    (oCpuStall)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  data;
        logic        ack;
        logic [7:0]  rdata;
        logic        busy;
        logic        req;
        logic [15:0] addr;
        logic        owe;
        logic [7:0]  oaddr;
        logic [7:0]  odata;
        logic [7:0]  dma;
        logic        done;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] eff(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

    function automatic vec_t mk(input logic we, input logic [7:0] data, input logic ack,
                                input logic [7:0] rdata, input logic busy, input logic req,
                                input logic [15:0] addr, input logic owe, input logic [7:0] oaddr,
                                input logic [7:0] odata, input logic [7:0] dma, input logic done);
        vec_t v;
        v.we = we; v.data = data; v.ack = ack; v.rdata = rdata;
        v.busy = busy; v.req = req; v.addr = addr; v.owe = owe;
        v.oaddr = oaddr; v.odata = odata; v.dma = dma; v.done = done;
        return v;
    endfunction

    // mode: 0 none, 1 restart during READ of byte trig_idx,
    //       2 restart during WRITE of byte trig_idx, 3 restart on the oDone cycle
    task automatic run_xfer(input logic [7:0] src, input int stall_idx, input int stall_len,
                            input int mode, input int trig_idx, input logic [7:0] src2,
                            input int reset_idx,
                            output int n_wr, output int pre_wr, output int last_wr,
                            output int done_rel, output int n_done, output int n_err);
        logic [7:0] hi;
        int idx, start, stall_cnt, idle_cnt;
        bit trig, restarted, rst_hit;
        hi = eff(src);
        idx = 0; start = 0; stall_cnt = 0; idle_cnt = 0;
        restarted = 0; rst_hit = 0;
        n_wr = 0; pre_wr = -1; last_wr = -1; done_rel = -1; n_done = 0; n_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iReset   = 1'b0;
            iDmaWe   = (cyc == 0);
            iDmaData = src;
            trig     = 0;
            if (!restarted && mode == 1 && oMcuReadReq && idx == trig_idx) trig = 1;
            if (!restarted && mode == 2 && oOamWe && idx == trig_idx) trig = 1;
            if (!restarted && mode == 3 && oDone) trig = 1;
            if (trig) begin
                iDmaWe   = 1'b1;
                iDmaData = src2;
            end
            iMcuReadAck  = 1'b0;
            iMcuReadData = 8'h00;
            if (oMcuReadReq) begin
                if (idx == stall_idx && stall_cnt < stall_len) begin
                    stall_cnt++;
                end else begin
                    iMcuReadAck  = 1'b1;
                    iMcuReadData = mem(oMcuAddr);
                end
            end
            if (!rst_hit && reset_idx >= 0 && oMcuReadReq && idx == reset_idx) begin
                iReset  = 1'b1;
                rst_hit = 1;
                #1;
                check("reset_mid_outputs",
                      {oBusy, oMcuReadReq, oMcuAddr, oOamWe, oOamAddr, oOamData, oDMA, oDone, oCpuStall}, 64'h0);
            end
            @(negedge iClock);
            if (oMcuReadReq && oOamWe) n_err++;
            if (oMcuReadReq && oMcuAddr !== {hi, idx[7:0]}) n_err++;
`ifdef DMA_CPU_STALL_EN
            if (oCpuStall !== oBusy) n_err++;
`else
            if (oCpuStall !== 1'b0) n_err++;
`endif
            if (oOamWe) begin
                if (oOamAddr !== idx[7:0] || oOamData !== mem({hi, idx[7:0]})) n_err++;
                n_wr++;
                last_wr = cyc - start;
                idx++;
            end
            if (oDone) begin
                n_done++;
                done_rel = cyc - start;
            end
            if (rst_hit && (oMcuReadReq || oOamWe || oDone || oBusy)) n_err++;
            if (trig) begin
                pre_wr    = n_wr;
                n_wr      = 0;
                hi        = eff(src2);
                idx       = 0;
                start     = cyc;
                restarted = 1;
            end
            if (!oBusy && (cyc - start) > 1) idle_cnt++;
            else idle_cnt = 0;
            @(posedge iClock);
            #1;
            if (idle_cnt >= 10) break;
        end
        iDmaWe      = 1'b0;
        iMcuReadAck = 1'b0;
        iReset      = 1'b0;
    endtask

    int n_wr, pre_wr, last_wr, done_rel, n_done, n_err;

    initial begin
        iReset = 1'b1; iDmaWe = 1'b0; iDmaData = 8'h00;
        iMcuReadAck = 1'b0; iMcuReadData = 8'h00;

        //            we    data   ack   rdata  busy  req   addr      owe   oaddr  odata  dma    done
        vecs[0]  = mk(1'b1, 8'hC0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[1]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0);
        vecs[2]  = mk(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'hC000, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1, 16'hC000, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h5A, 8'hC0, 1'b0);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 16'hC001, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h01, 8'hA5, 8'hC0, 1'b0);
        vecs[8]  = mk(1'b1, 8'hE3, 1'b1, 8'h77, 1'b1, 1'b1, 16'hC002, 1'b0, 8'h00, 8'h00, 8'hC0, 1'b0);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'hE3, 1'b0);
        vecs[10] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'hE3, 1'b0);
        vecs[11] = mk(1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 1'b1, 16'hC300, 1'b0, 8'h00, 8'h00, 8'hE3, 1'b0);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h42, 8'hE3, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'hC301, 1'b0, 8'h00, 8'h00, 8'hE3, 1'b0);

        repeat (3) @(posedge iClock);
        #1;
        check("reset_state",
              {oBusy, oMcuReadReq, oMcuAddr, oOamWe, oOamAddr, oOamData, oDMA, oDone, oCpuStall}, 64'h0);
        iReset = 1'b0;
        @(posedge iClock);
        #1;

        for (int i = 0; i < 14; i++) begin
            iDmaWe       = vecs[i].we;
            iDmaData     = vecs[i].data;
            iMcuReadAck  = vecs[i].ack;
            iMcuReadData = vecs[i].rdata;
            @(negedge iClock);
            check($sformatf("vec%0d", i),
                  {oBusy, oMcuReadReq, oMcuAddr, oOamWe, oOamAddr, oOamData, oDMA, oDone},
                  {vecs[i].busy, vecs[i].req, vecs[i].addr, vecs[i].owe,
                   vecs[i].oaddr, vecs[i].odata, vecs[i].dma, vecs[i].done});
`ifdef DMA_CPU_STALL_EN
            check($sformatf("vec%0d_stall", i), oCpuStall, vecs[i].busy);
`else
            check($sformatf("vec%0d_stall", i), oCpuStall, 1'b0);
`endif
            @(posedge iClock);
            #1;
        end
        iDmaWe = 1'b0; iMcuReadAck = 1'b0;
        iReset = 1'b1;
        #1;
        iReset = 1'b0;
        @(posedge iClock);
        #1;

        // Plain transfer, zero-wait ack
        run_xfer(8'hC0, -1, 0, 0, 0, 8'h00, -1, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t1_writes", n_wr, 160);
        check("t1_last_write_cycle", last_wr, 322);
        check("t1_done_cycle", done_rel, 323);
        check("t1_done_count", n_done, 1);
        check("t1_stream_errors", n_err, 0);
        check("t1_dma", oDMA, 8'hC0);
        check("t1_idle", oBusy, 1'b0);

        // Ack held off 5 cycles on byte 3
        run_xfer(8'hC0, 3, 5, 0, 0, 8'h00, -1, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t2_writes", n_wr, 160);
        check("t2_last_write_cycle", last_wr, 327);
        check("t2_done_count", n_done, 1);
        check("t2_stream_errors", n_err, 0);

        // Restart to D0 while reading byte 50
        run_xfer(8'hC0, -1, 0, 1, 50, 8'hD0, -1, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t3_pre_abort_writes", pre_wr, 50);
        check("t3_writes", n_wr, 160);
        check("t3_last_write_cycle", last_wr, 322);
        check("t3_done_count", n_done, 1);
        check("t3_stream_errors", n_err, 0);
        check("t3_dma", oDMA, 8'hD0);

        // Echo-RAM source
        run_xfer(8'hE1, -1, 0, 0, 0, 8'h00, -1, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t4_writes", n_wr, 160);
        check("t4_stream_errors", n_err, 0);
        check("t4_dma", oDMA, 8'hE1);

        // Reset while reading byte 80
        run_xfer(8'hC0, -1, 0, 0, 0, 8'h00, 80, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t5_writes_before_reset", n_wr, 80);
        check("t5_done_count", n_done, 0);
        check("t5_stream_errors", n_err, 0);
        check("t5_dma", oDMA, 8'h00);

        // Restart in the same cycle as the final write
        run_xfer(8'hC0, -1, 0, 2, 159, 8'hC8, -1, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t6_final_write_kept", pre_wr, 160);
        check("t6_writes", n_wr, 160);
        check("t6_done_count", n_done, 1);
        check("t6_stream_errors", n_err, 0);
        check("t6_dma", oDMA, 8'hC8);

        // Restart in the oDone cycle: both transfers report done
        run_xfer(8'hC0, -1, 0, 3, 0, 8'hC4, -1, n_wr, pre_wr, last_wr, done_rel, n_done, n_err);
        check("t7_first_writes", pre_wr, 160);
        check("t7_writes", n_wr, 160);
        check("t7_done_count", n_done, 2);
        check("t7_done_cycle", done_rel, 323);
        check("t7_stream_errors", n_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
